// File: rtl/sha256_pkg.sv
// SHA-256 constants, round functions and compression-FSM state encoding.
// Shared by the compression core and the upstream message scheduler.
package sha256_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ROUND = 2'd1;
  localparam logic [1:0] ST_FINAL = 2'd2;

  localparam logic [5:0] LAST_ROUND = 6'd63;

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// Round-constant lookup: K[t] for the current round index, zero latency.
// Purely combinational, no flow control.
module sha256_k_rom
  import sha256_pkg::*;
(
  input  logic [5:0]  i_idx,
  output logic [31:0] o_k
);

  assign o_k = K[i_idx];

endmodule

// File: rtl/sha256_compress.sv
// SHA-256 compression: one block per 66 cycles (accept, 64 rounds, final add).
// o_ready is high only in IDLE; i_start outside IDLE is dropped, never queued.
module sha256_compress
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  input  logic         i_first,
  input  logic [31:0]  i_w,
  output logic         o_ready,
  output logic         o_valid,
  output logic [255:0] o_digest
);

  logic [1:0]   r_state;
  logic [5:0]   r_t;
  logic [31:0]  r_wv [8];
  logic [31:0]  r_hv [8];
  logic         r_valid;
  logic [255:0] r_digest;

  logic [31:0]  w_k;
  logic [31:0]  w_t1;
  logic [31:0]  w_t2;
  logic [31:0]  w_hsum [8];
  logic [255:0] w_hsum_flat;

  sha256_k_rom u_k_rom (
    .i_idx (r_t),
    .o_k   (w_k)
  );

  // r_wv[0..7] hold working variables a..h
  always_comb begin
    w_t1 = r_wv[7] + big_sigma1(r_wv[4]) + ch(r_wv[4], r_wv[5], r_wv[6]) + w_k + i_w;
    w_t2 = big_sigma0(r_wv[0]) + maj(r_wv[0], r_wv[1], r_wv[2]);
    w_hsum_flat = '0;
    for (int i = 0; i < 8; i++) begin
      w_hsum[i] = r_hv[i] + r_wv[i];
      w_hsum_flat[255 - 32*i -: 32] = w_hsum[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_t      <= '0;
      r_valid  <= 1'b0;
      r_digest <= '0;
      for (int i = 0; i < 8; i++) begin
        r_hv[i] <= IV[i];
        r_wv[i] <= '0;
      end
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state <= ST_ROUND;
            r_t     <= '0;
            for (int i = 0; i < 8; i++) begin
              if (i_first) begin
                r_hv[i] <= IV[i];
                r_wv[i] <= IV[i];
              end else begin
                r_wv[i] <= r_hv[i];
              end
            end
          end
        end
        ST_ROUND: begin
          r_wv[7] <= r_wv[6];
          r_wv[6] <= r_wv[5];
          r_wv[5] <= r_wv[4];
          r_wv[4] <= r_wv[3] + w_t1;
          r_wv[3] <= r_wv[2];
          r_wv[2] <= r_wv[1];
          r_wv[1] <= r_wv[0];
          r_wv[0] <= w_t1 + w_t2;
          r_t     <= r_t + 6'd1;
          if (r_t == LAST_ROUND) begin
            r_state <= ST_FINAL;
          end
        end
        ST_FINAL: begin
          for (int i = 0; i < 8; i++) begin
            r_hv[i] <= w_hsum[i];
          end
          r_digest <= w_hsum_flat;
          r_valid  <= 1'b1;
          r_state  <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_ready  = (r_state == ST_IDLE);
  assign o_valid  = r_valid;
  assign o_digest = r_digest;

endmodule

// File: tb/tb_sha256_compress.sv
// Self-checking bench for sha256_compress: known-answer vectors plus random
// blocks checked against a loop-based SHA-256 reference model.
module tb_sha256_compress;

  logic         clk;
  logic         rst;
  logic         i_start;
  logic         i_first;
  logic [31:0]  i_w;
  logic         o_ready;
  logic         o_valid;
  logic [255:0] o_digest;

  int n_checks;
  int n_errors;

  localparam logic [255:0] IV_T =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

  localparam logic [2047:0] K_T = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] BLK_TWO1  = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869, 32'h6768696a,
    32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071,
    32'h80000000, 32'h00000000
  };
  localparam logic [511:0] BLK_TWO2  = {448'h0, 64'h1c0};

  localparam logic [255:0] DIG_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_EMPTY =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] DIG_TWO =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  sha256_compress dut (
    .clk      (clk),
    .rst      (rst),
    .i_start  (i_start),
    .i_first  (i_first),
    .i_w      (i_w),
    .o_ready  (o_ready),
    .o_valid  (o_valid),
    .o_digest (o_digest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] kt(input int t);
    logic [2047:0] k;
    k = K_T;
    return k[2047 - 32*t -: 32];
  endfunction

  // Message schedule, recomputed from the block each call (bench stands in for the scheduler).
  function automatic logic [31:0] sched_word(input logic [511:0] blk, input int idx);
    logic [31:0] w [64];
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
           + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    return w[idx];
  endfunction

  function automatic logic [255:0] ref_block(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0]  v [8];
    logic [31:0]  t1;
    logic [31:0]  t2;
    logic [255:0] r;
    for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + kt(t) + sched_word(blk, t);
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    r = '0;
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
    return r;
  endfunction

  // Caller is at a negedge. Returns at the negedge where o_valid is seen
  // (lat = cycles since i_start), or after the abort-reset checks (lat = 0).
  task automatic run_block(input logic [511:0] blk, input logic first, input bit busy,
                           input int abort_k, output int lat, output int ready_bad);
    i_start   = 1'b1;
    i_first   = first;
    lat       = -1;
    ready_bad = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (rst) begin
        chk("abort_ready", {255'h0, o_ready}, 256'h1);
        chk("abort_valid", {255'h0, o_valid}, 256'h0);
        chk("abort_digest", o_digest, 256'h0);
        rst = 1'b0;
        lat = 0;
        break;
      end
      if (o_valid) begin
        lat = k;
        break;
      end
      if (o_ready) ready_bad++;
      i_start = busy && (k == 10 || k == 40);
      i_first = 1'($urandom_range(0, 1));
      i_w     = (k <= 64) ? sched_word(blk, k - 1) : $urandom();
      if (abort_k != 0 && k == abort_k) rst = 1'b1;
    end
    i_start = 1'b0;
  endtask

  logic [255:0] model_h;
  logic [255:0] exp_d;
  logic [255:0] saved;
  logic [511:0] rblk;
  logic         rfirst;
  int           lat;
  int           rbad;
  int           hold_bad;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    i_start  = 1'b0;
    i_first  = 1'b0;
    i_w      = '0;
    repeat (3) @(negedge clk);
    chk("reset_ready", {255'h0, o_ready}, 256'h1);
    chk("reset_valid", {255'h0, o_valid}, 256'h0);
    chk("reset_digest", o_digest, 256'h0);
    rst = 1'b0;
    @(negedge clk);
    model_h = IV_T;

    run_block(BLK_ABC, 1'b1, 1'b0, 0, lat, rbad);
    chk("abc_latency", lat, 66);
    chk("abc_ready_busy", rbad, 0);
    chk("abc_digest", o_digest, DIG_ABC);
    chk("abc_model", o_digest, ref_block(IV_T, BLK_ABC));
    model_h = DIG_ABC;

    @(negedge clk);
    run_block(BLK_EMPTY, 1'b1, 1'b0, 0, lat, rbad);
    chk("empty_latency", lat, 66);
    chk("empty_digest", o_digest, DIG_EMPTY);

    // Second block starts at the same negedge that sees the first o_valid.
    @(negedge clk);
    run_block(BLK_TWO1, 1'b1, 1'b0, 0, lat, rbad);
    chk("two1_latency", lat, 66);
    chk("two1_model", o_digest, ref_block(IV_T, BLK_TWO1));
    run_block(BLK_TWO2, 1'b0, 1'b0, 0, lat, rbad);
    chk("two2_latency", lat, 66);
    chk("two2_ready_busy", rbad, 0);
    chk("two2_digest", o_digest, DIG_TWO);
    model_h = DIG_TWO;

    saved    = o_digest;
    hold_bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (o_digest !== saved || o_valid !== 1'b0) hold_bad++;
      i_w = $urandom();
    end
    chk("hold_stable", hold_bad, 0);

    run_block(BLK_ABC, 1'b1, 1'b1, 0, lat, rbad);
    chk("busy_latency", lat, 66);
    chk("busy_ready", rbad, 0);
    chk("busy_digest", o_digest, DIG_ABC);
    model_h = DIG_ABC;
    @(negedge clk);
    chk("valid_one_pulse", {255'h0, o_valid}, 256'h0);

    run_block(BLK_EMPTY, 1'b1, 1'b0, 31, lat, rbad);
    chk("abort_path", lat, 0);
    model_h = IV_T;
    @(negedge clk);
    run_block(BLK_ABC, 1'b1, 1'b0, 0, lat, rbad);
    chk("after_abort_digest", o_digest, DIG_ABC);

    @(negedge clk);
    run_block(BLK_EMPTY, 1'b1, 1'b0, 20, lat, rbad);
    @(negedge clk);
    run_block(BLK_ABC, 1'b0, 1'b0, 0, lat, rbad);
    chk("abort_chain_iv", o_digest, DIG_ABC);
    model_h = DIG_ABC;

    for (int n = 0; n < 6; n++) begin
      rblk = '0;
      for (int j = 0; j < 16; j++) rblk[511 - 32*j -: 32] = $urandom();
      rfirst = 1'($urandom_range(0, 1));
      exp_d  = ref_block(rfirst ? IV_T : model_h, rblk);
      if (n % 2 == 0) @(negedge clk);
      run_block(rblk, rfirst, 1'($urandom_range(0, 1)), 0, lat, rbad);
      chk("rand_latency", lat, 66);
      chk("rand_digest", o_digest, exp_d);
      model_h = exp_d;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sha256_compress.md
# sha256_compress

SHA-256 compression core sitting directly downstream of the message scheduler. It consumes the 64-word W_t stream that the scheduler emits one word per cycle and runs the 64 compression rounds. At the end of each block it adds the working variables into the chaining state and presents the 256-bit intermediate or final digest. The parent asserts this block's i_start in the same cycle as the scheduler's i_enable, so the two stay cycle-locked with no FIFO between them.

## Interface
- No parameters. Widths are fixed by SHA-256.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- i_start  in  1  begin one block; sampled only in IDLE
- i_first  in  1  sampled with i_start; 1 = first block of a message, chain from IV; 0 = chain from current H
- i_w  in  32  W_t from the scheduler's W_out; W_0 is valid the cycle after i_start is accepted
- o_ready  out  1  high in IDLE only
- o_valid  out  1  one-cycle pulse when o_digest is updated
- o_digest  out  256  {H0..H7}, H0 in bits [255:224]; holds between updates

## Operation
- States:
  - IDLE: o_ready=1.
  - ROUND: 64 cycles, round counter t = 0..63.
  - FINAL: 1 cycle.
- IDLE -> ROUND on i_start. On that edge:
  - If i_first=1: H and a..h are both loaded with IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19).
  - If i_first=0: a..h are loaded from H.
  - t is cleared to 0.
- ROUND, each edge:
  - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + i_w
  - T2 = Σ0(a) + Maj(a,b,c)
  - h..a <= g, f, e, d+T1, c, b, a, T1+T2
  - t <= t+1
  - The edge at t=63 moves to FINAL.
- Arithmetic: all additions are mod 2^32 with carries discarded. Σ0 = ROTR2^ROTR13^ROTR22. Σ1 = ROTR6^ROTR11^ROTR25.
- FINAL edge:
  - Hi <= Hi + working var i, for all 8 words.
  - o_digest <= the new H.
  - o_valid <= 1.
  - Next state is IDLE.
- i_start while not in IDLE is ignored; no queuing. The parent must not pulse the scheduler either.
- i_first is ignored when i_start is not accepted.
- Reset has priority over everything. Reset mid-ROUND or mid-FINAL aborts the block with no partial digest update. After the block aborts, the next i_start must have i_first=1; an i_start with i_first=0 chains from IV.
- Reset values:
  - state = IDLE, t = 0, o_valid = 0, o_ready = 1 from the cycle after rst
  - o_digest = 0, H = IV, a..h = 0

## Timing
- Edge E0 accepts i_start.
- Edges E1..E64 perform rounds 0..63, consuming i_w = W_0..W_63. This matches the scheduler: it loads W_0 onto W_out at E0 and advances one word per edge.
- E65 performs FINAL. o_valid is high in the cycle after E65 and o_digest is valid from then on.
- o_ready is high again after E65, so the earliest back-to-back i_start is sampled at E66.
- Block-to-block throughput is 66 cycles.
- i_w is ignored outside ROUND.

## Structure
- Package sha256_pkg holds:
  - IV constants
  - K[0:63] constant array
  - Functions ch, maj, big_sigma0, big_sigma1, plus the scheduler's small sigma0/sigma1 (moved there for sharing)
  - State encoding localparams
- Sub-module sha256_k_rom: combinational 6-bit index to 32-bit K lookup, indexed by t.
- Top level: FSM, round counter, a..h registers, H registers, output register.

## Test plan
- **"abc" single block** (padded block 61626380 00…00 00000018), i_first=1, driven through the real scheduler: o_valid exactly 66 cycles after i_start; o_digest = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- **Empty message** (block 80000000 00…00), i_first=1: o_digest = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- **Two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq"**:
  - Block 1 with i_first=1, then block 2 with i_first=0 started at the first legal cycle (E66).
  - Final o_digest = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
  - o_valid pulses once per block.
- **Busy protection**: pulse i_start at E10 and E40 of a running "abc" block -> both ignored; o_ready=0 throughout; digest unchanged from the "abc" value.
- **Reset mid-block**: rst at round 30 -> the next cycle shows o_ready=1, o_valid=0, o_digest=0. A fresh "abc" with i_first=1 then gives the correct digest.
- **Hold check**: after o_valid, leave the block idle for 100 cycles with random i_w -> o_digest is stable and o_valid stays 0.
